// File: rtl/hazard_pkg.sv
// Shared select encoding and stage-record type for the hazard/forwarding controller.
// Register addresses are zero-extended to HAZARD_AW_MAX bits inside the shadow pipe.
package hazard_pkg;

  localparam int HAZARD_AW_MAX = 8;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_RSVD    = 2'b11;

  typedef logic [HAZARD_AW_MAX-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t dst;
    logic      rw;
    logic      load;
  } stage_rec_t;

endpackage

// File: rtl/fwd_select.sv
// Combinational operand-select for one EX mux input: compares the consumer
// source against the M and W producer records, M winning over W.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int ZERO_REG_EN = 1
) (
  input  logic       consumer_valid,
  input  reg_addr_t  src,
  input  stage_rec_t m_rec,
  input  stage_rec_t w_rec,
  output logic [1:0] sel
);

  logic src_live;
  logic m_hit;
  logic w_hit;
  logic unused_w_load;

  assign unused_w_load = w_rec.load;

  // A bubble in E selects nothing; register 0 is hard-wired when enabled.
  assign src_live = consumer_valid && !((ZERO_REG_EN != 0) && (src == '0));
  assign m_hit    = m_rec.valid && m_rec.rw && !m_rec.load && (m_rec.dst == src);
  assign w_hit    = w_rec.valid && w_rec.rw && (w_rec.dst == src);

  always_comb begin
    sel = FWD_REGFILE;
    if (src_live) begin
      if (m_hit) begin
        sel = FWD_MEM;
      end else if (w_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline with shadow E/M/W records.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       perf_stalls,
  output logic [31:0]       perf_flushes,
`endif
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_mispredict,
  input  logic              mem_wait,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e
);

  stage_rec_t e_rec;
  stage_rec_t m_rec;
  stage_rec_t w_rec;
  reg_addr_t  e_src_a;
  reg_addr_t  e_src_b;
  logic       run;

  reg_addr_t  id_a;
  reg_addr_t  id_b;
  reg_addr_t  id_d;
  logic       e_dst_live;
  logic       lu;
  logic       freeze;
  logic       mp_act;
  logic       lu_act;

  assign id_a = reg_addr_t'(id_src_a);
  assign id_b = reg_addr_t'(id_src_b);
  assign id_d = reg_addr_t'(id_dst);

  assign e_dst_live = !((ZERO_REG_EN != 0) && (e_rec.dst == '0));
  assign lu = id_valid && e_rec.valid && e_rec.load && e_rec.rw && e_dst_live &&
              ((e_rec.dst == id_a) || (e_rec.dst == id_b));

  // run stays low for the first cycle after reset so every control output is quiet.
  assign freeze = run && mem_wait;
  assign mp_act = run && ex_mispredict && !mem_wait;
  assign lu_act = run && lu && !mem_wait && !ex_mispredict;

  assign stall_f = freeze || lu_act;
  assign stall_d = freeze || lu_act;
  assign flush_d = mp_act;
  assign flush_e = mp_act || lu_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rec   <= '0;
      m_rec   <= '0;
      w_rec   <= '0;
      e_src_a <= '0;
      e_src_b <= '0;
`ifdef HAZARD_PERF_CNT_EN
      perf_stalls  <= '0;
      perf_flushes <= '0;
`endif
    end else begin
      if (!freeze) begin
        w_rec.valid <= m_rec.valid;
        w_rec.dst   <= m_rec.dst;
        w_rec.rw    <= m_rec.rw;
        w_rec.load  <= 1'b0;
        m_rec       <= e_rec;
        e_rec.valid <= id_valid && !lu && !(run && ex_mispredict);
        e_rec.dst   <= id_d;
        e_rec.rw    <= id_reg_write;
        e_rec.load  <= id_is_load;
        e_src_a     <= id_a;
        e_src_b     <= id_b;
      end
`ifdef HAZARD_PERF_CNT_EN
      if (lu_act && (perf_stalls != '1)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
      if (mp_act && (perf_flushes != '1)) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
`endif
    end
  end

  fwd_select #(.ZERO_REG_EN(ZERO_REG_EN)) u_fwd_a (
    .consumer_valid (e_rec.valid),
    .src            (e_src_a),
    .m_rec          (m_rec),
    .w_rec          (w_rec),
    .sel            (fwd_sel_a)
  );

  fwd_select #(.ZERO_REG_EN(ZERO_REG_EN)) u_fwd_b (
    .consumer_valid (e_rec.valid),
    .src            (e_src_b),
    .m_rec          (m_rec),
    .w_rec          (w_rec),
    .sel            (fwd_sel_b)
  );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use, mispredict, mem_wait, r0 and priority.
module tb_hazard_fwd_ctrl;

  localparam int REG_AW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_src_a = '0;
  logic [REG_AW-1:0] id_src_b = '0;
  logic [REG_AW-1:0] id_dst = '0;
  logic              id_reg_write = 1'b0;
  logic              id_is_load = 1'b0;
  logic              ex_mispredict = 1'b0;
  logic              mem_wait = 1'b0;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       perf_stalls;
  logic [31:0]       perf_flushes;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(REG_AW), .ZERO_REG_EN(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stalls   (perf_stalls),
    .perf_flushes  (perf_flushes),
`endif
    .id_valid      (id_valid),
    .id_src_a      (id_src_a),
    .id_src_b      (id_src_b),
    .id_dst        (id_dst),
    .id_reg_write  (id_reg_write),
    .id_is_load    (id_is_load),
    .ex_mispredict (ex_mispredict),
    .mem_wait      (mem_wait),
    .fwd_sel_a     (fwd_sel_a),
    .fwd_sel_b     (fwd_sel_b),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .flush_e       (flush_e)
  );

  task automatic drive(input logic v, input int a, input int b, input int d,
                       input logic rw, input logic ld);
    id_valid     = v;
    id_src_a     = REG_AW'(a);
    id_src_b     = REG_AW'(b);
    id_dst       = REG_AW'(d);
    id_reg_write = rw;
    id_is_load   = ld;
  endtask

  task automatic idle_d();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_d();
    repeat (3) tick();
  endtask

  // Compares {sel_a, sel_b, stall_f, stall_d, flush_d, flush_e} two units after inputs settle.
  task automatic chk(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                     input logic sf, input logic sd, input logic fd, input logic fe);
    logic [7:0] obs;
    logic [7:0] req;
    logic       load_in_m;
    #2;
    obs = {fwd_sel_a, fwd_sel_b, stall_f, stall_d, flush_d, flush_e};
    req = {ea, eb, sf, sd, fd, fe};
    n_chk++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s obs=%b req=%b (sel_a sel_b stall_f stall_d flush_d flush_e)", tag, obs, req);
    load_in_m = dut.m_rec.valid && dut.m_rec.load && dut.m_rec.rw && dut.e_rec.valid &&
                (dut.m_rec.dst != '0) &&
                ((dut.m_rec.dst == dut.e_src_a) || (dut.m_rec.dst == dut.e_src_b));
    n_chk++;
    assert (load_in_m === 1'b0) n_pass++;
    else $error("FAIL %s_load_in_m obs=%b req=0", tag, load_in_m);
  endtask

  initial begin
    // Reset held with random inputs: every output quiet.
    repeat (3) begin
      tick();
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ex_mispredict = 1'($urandom_range(0, 1));
      mem_wait      = 1'($urandom_range(0, 1));
      chk("reset", 2'b00, 2'b00, 0, 0, 0, 0);
    end
    tick();
    rst_n = 1'b1;
    idle_d();
    ex_mispredict = 1'b1;
    mem_wait      = 1'b1;
    chk("first_cycle", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    ex_mispredict = 1'b0;
    mem_wait      = 1'b0;
    chk("idle", 2'b00, 2'b00, 0, 0, 0, 0);

    // ALU-ALU back-to-back on r3.
    tick();
    drive(1, 1, 2, 3, 1, 0);
    chk("alu_d_add", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 3, 6, 7, 1, 0);
    chk("alu_e_add", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 8, 3, 9, 1, 0);
    chk("alu_fwd_mem_a", 2'b10, 2'b00, 0, 0, 0, 0);
    tick();
    idle_d();
    chk("alu_fwd_wb_b", 2'b00, 2'b01, 0, 0, 0, 0);
    tick();
    chk("alu_tail", 2'b00, 2'b00, 0, 0, 0, 0);
    drain();

    // Load-use on r5 via src_b: exactly one bubble.
    drive(1, 1, 0, 5, 1, 1);
    chk("lu_d_ldr", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 2, 5, 6, 1, 0);
    chk("lu_stall", 2'b00, 2'b00, 1, 1, 0, 1);
    tick();
    chk("lu_bubble", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    idle_d();
    chk("lu_fwd_wb_b", 2'b00, 2'b01, 0, 0, 0, 0);
    drain();

    // Mispredict in the same cycle as a load-use.
    tick();
    drive(1, 1, 1, 5, 1, 1);
    chk("mp_d_ldr", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 5, 0, 6, 1, 0);
    ex_mispredict = 1'b1;
    chk("mp_over_lu", 2'b00, 2'b00, 0, 0, 1, 1);
    tick();
    ex_mispredict = 1'b0;
    idle_d();
    chk("mp_bubble", 2'b00, 2'b00, 0, 0, 0, 0);
    drain();

    // mem_wait for three cycles with r2 forwarding from M.
    tick();
    drive(1, 1, 1, 2, 1, 0);
    tick();
    drive(1, 2, 4, 8, 1, 0);
    tick();
    idle_d();
    mem_wait = 1'b1;
    chk("wait_1", 2'b10, 2'b00, 1, 1, 0, 0);
    tick();
    ex_mispredict = 1'b1;
    chk("wait_2_mp", 2'b10, 2'b00, 1, 1, 0, 0);
    tick();
    ex_mispredict = 1'b0;
    chk("wait_3", 2'b10, 2'b00, 1, 1, 0, 0);
    tick();
    mem_wait = 1'b0;
    chk("wait_release", 2'b10, 2'b00, 0, 0, 0, 0);
    tick();
    chk("wait_advance", 2'b00, 2'b00, 0, 0, 0, 0);
    drain();

    // Register 0 never stalls or forwards.
    tick();
    drive(1, 1, 1, 0, 1, 1);
    tick();
    drive(1, 0, 0, 0, 1, 0);
    chk("r0_no_stall", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 9, 1, 0);
    chk("r0_e_add", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    idle_d();
    chk("r0_no_fwd", 2'b00, 2'b00, 0, 0, 0, 0);
    drain();

    // r4 written in both M and W: M wins.
    tick();
    drive(1, 1, 1, 4, 1, 0);
    tick();
    drive(1, 1, 1, 4, 1, 0);
    tick();
    drive(1, 4, 4, 10, 1, 0);
    chk("prio_e_i2", 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    idle_d();
    chk("prio_mem", 2'b10, 2'b10, 0, 0, 0, 0);
    drain();

`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    assert (perf_stalls === 32'd1) n_pass++;
    else $error("FAIL perf_stalls obs=%0d req=1", perf_stalls);
    n_chk++;
    assert (perf_flushes === 32'd1) n_pass++;
    else $error("FAIL perf_flushes obs=%0d req=1", perf_flushes);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline (F, D, E, M, W).
- Drives the 2-bit selects of the two EX-stage 4:1 operand muxes and the fetch/decode stall and decode/execute flush controls.
- Keeps its own shadow copy of destination and control bits for E, M and W, advanced in lockstep with the datapath pipeline registers.
- Datapath pipeline registers consume its stall and flush outputs directly.

Parameters:
- REG_AW, 4, register-address width.
- ZERO_REG_EN, 1, if 1 then register 0 never forwards and never causes a stall.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  D-stage holds a real instruction
- id_src_a  in  REG_AW  D-stage source register A
- id_src_b  in  REG_AW  D-stage source register B
- id_dst  in  REG_AW  D-stage destination register
- id_reg_write  in  1  D-stage instruction writes the register file
- id_is_load  in  1  D-stage instruction is a load
- ex_mispredict  in  1  branch resolved wrong in E this cycle
- mem_wait  in  1  data memory not ready; freezes the whole pipe
- fwd_sel_a  out  2  select for EX operand-A mux
- fwd_sel_b  out  2  select for EX operand-B mux
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_d  out  1  clear F/D register
- flush_e  out  1  load bubble into D/E register

Behaviour:
- Shadow stages: E holds {valid, src_a, src_b, dst, rw, load}; M holds {valid, dst, rw, load}; W holds {valid, dst, rw}. All are registers on clk with asynchronous clear on rst_n low. Reset clears every valid bit.
- Reset values: all outputs 0 during reset and in the first cycle after it. No stall, no flush, select 00.
- Select encoding, shared with the mux: 00 register-file value; 01 W result; 10 M ALU result; 11 reserved, never driven.
- Forwarding is combinational from the shadow state, so it is valid in the same cycle the instruction sits in E. Rules, applied per operand X:
  - 10 if M.valid, M.rw, !M.load and M.dst == E.src_X.
  - Otherwise 01 if W.valid, W.rw and W.dst == E.src_X.
  - Otherwise 00.
  - M takes priority over W.
- A match on register 0 is ignored when ZERO_REG_EN=1.
- Load-use hazard: lu = id_valid & E.valid & E.load & E.rw & (E.dst == id_src_a or E.dst == id_src_b), with register-0 exclusion. When lu is set: stall_f = stall_d = 1 and flush_e = 1, giving exactly one bubble.
- Mispredict: flush_d = flush_e = 1. Mispredict wins over lu: stall_f and stall_d are forced to 0 because the D instruction is being discarded.
- mem_wait = 1 freezes the shadow registers and the F/D stages:
  - stall_f = stall_d = 1; flush_d and flush_e are forced to 0.
  - fwd_sel keeps its value, because the shadow state is unchanged.
  - mem_wait has the highest priority. A mispredict that arrives during mem_wait is not latched. The EX stage holds, so ex_mispredict is re-presented after the wait ends and is acted on then.
- Advance, when not frozen:
  - W takes M.
  - M takes E.
  - E takes the D fields, with valid = id_valid & !lu & !ex_mispredict.
- Bubbles and flushed slots have valid = 0 and never forward.
- Reset asserted mid-operation clears all shadow state immediately. Instructions in flight are treated as bubbles.
- M.load with a matching dst is unreachable, because lu guarantees the bubble. The bench asserts this never occurs.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs perf_stalls (32) and perf_flushes (32), plus sub-counters in the same always block.
  - perf_stalls increments on each cycle lu is acted on.
  - perf_flushes increments on each mispredict acted on.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- hazard_pkg contains the FWD_REGFILE/FWD_WB/FWD_MEM/FWD_RSVD 2-bit constants and the stage-record typedef {valid, dst, rw, load}.
- Sub-module fwd_select: purely combinational, compares one operand against the M and W records and outputs its 2-bit select. It is instantiated twice, for operands A and B.

Test Plan:
- Reset check: hold rst_n=0 while driving random inputs, then release → all outputs 0; fwd_sel 00 until a matching producer reaches M.
- ALU-ALU back-to-back: ADD r3 followed by SUB using r3 as src_a → fwd_sel_a=10 when SUB is in E; a third instruction that reads r3 on src_b → fwd_sel_b=01 when it is in E.
- Load-use: LDR r5 then ADD reading src_b=r5 → one cycle of stall_f=stall_d=flush_e=1, then fwd_sel_b=01 when ADD reaches E; no second stall.
- Mispredict together with lu: both in the same cycle → flush_d=flush_e=1, stall_f=stall_d=0; the next E slot is a bubble with fwd_sel 00.
- mem_wait held 3 cycles with r2 forwarding active → fwd_sel held, stall_f=stall_d=1, no flush, and the shadow pipe is unchanged after release.
- Register-0 and priority checks:
  - With ZERO_REG_EN=1, a write to r0 followed by a read of r0 → fwd_sel 00 and no stall.
  - Writes to r4 in both M and W → fwd_sel 10, because M has priority.
